// File: rtl/alu_ctrl_pkg.sv
// Shared opcode, ALU select and FSM state encodings for the ALU arbiter and
// any issue logic that needs to pre-decode opcodes.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_SLL = 4'd3;
  localparam logic [3:0] OP_SRA = 4'd4;
  localparam logic [3:0] OP_SRL = 4'd5;
  localparam logic [3:0] OP_SNE = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_SGT = 4'd8;
  localparam logic [3:0] OP_SLE = 4'd9;
  localparam logic [3:0] OP_SGE = 4'd10;
  localparam logic [3:0] OP_SUB = 4'd11;
  localparam logic [3:0] OP_ADD = 4'd12;

  // {sel5..sel0} as seen by the ALU
  localparam logic [5:0] SEL_AND = 6'b000000;
  localparam logic [5:0] SEL_OR  = 6'b000001;
  localparam logic [5:0] SEL_XOR = 6'b000010;
  localparam logic [5:0] SEL_SLL = 6'b000110;
  localparam logic [5:0] SEL_SRA = 6'b000100;
  localparam logic [5:0] SEL_SRL = 6'b000101;
  localparam logic [5:0] SEL_SNE = 6'b110001;
  localparam logic [5:0] SEL_SLT = 6'b110010;
  localparam logic [5:0] SEL_SGT = 6'b110011;
  localparam logic [5:0] SEL_SLE = 6'b110100;
  localparam logic [5:0] SEL_SGE = 6'b110110;
  localparam logic [5:0] SEL_SUB = 6'b111000;
  localparam logic [5:0] SEL_ADD = 6'b100000;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  typedef struct packed {
    logic [5:0] sel;
    logic       legal;
    logic       is_shift;
  } op_dec_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request and response handshake bundle between issue logic and the arbiter.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_op;
  logic [WIDTH-1:0] req0_in1;
  logic [WIDTH-1:0] req0_in2;

  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_op;
  logic [WIDTH-1:0] req1_in1;
  logic [WIDTH-1:0] req1_in2;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output req0_valid, req0_op, req0_in1, req0_in2,
    input  req0_ready,
    output req1_valid, req1_op, req1_in1, req1_in2,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_op, req0_in1, req0_in2,
    output req0_ready,
    input  req1_valid, req1_op, req1_in1, req1_in2,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_err,
    input  rsp_ready
  );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: ALU select lines, legality and shift flag.
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] op,
  output op_dec_t    dec
);

  always_comb begin
    dec.sel      = SEL_AND;
    dec.legal    = 1'b1;
    dec.is_shift = 1'b0;
    case (op)
      OP_AND: dec.sel = SEL_AND;
      OP_OR:  dec.sel = SEL_OR;
      OP_XOR: dec.sel = SEL_XOR;
      OP_SLL: begin dec.sel = SEL_SLL; dec.is_shift = 1'b1; end
      OP_SRA: begin dec.sel = SEL_SRA; dec.is_shift = 1'b1; end
      OP_SRL: begin dec.sel = SEL_SRL; dec.is_shift = 1'b1; end
      OP_SNE: dec.sel = SEL_SNE;
      OP_SLT: dec.sel = SEL_SLT;
      OP_SGT: dec.sel = SEL_SGT;
      OP_SLE: dec.sel = SEL_SLE;
      OP_SGE: dec.sel = SEL_SGE;
      OP_SUB: dec.sel = SEL_SUB;
      OP_ADD: dec.sel = SEL_ADD;
      default: dec.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
//
// state | meaning
// IDLE  | waiting for a request; ready is offered to the arbitration winner
// EXEC  | ALU driven from captured operands; result captured at end of cycle
// RESP  | response held on rsp_*; returns to IDLE on rsp_ready
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [5:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  logic [1:0]       state;
  logic             last_grant;
  logic             grant;
  logic             accept;
  logic [3:0]       win_op;
  logic [WIDTH-1:0] win_in1;
  logic [WIDTH-1:0] win_in2;
  logic [WIDTH-1:0] win_shamt;
  op_dec_t          win_dec;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant;
    else                                  grant = bus.req1_valid;
    win_op  = grant ? bus.req1_op  : bus.req0_op;
    win_in1 = grant ? bus.req1_in1 : bus.req0_in1;
    win_in2 = grant ? bus.req1_in2 : bus.req0_in2;
  end

  assign win_shamt = {{(WIDTH-SHAMT_W){1'b0}}, win_in2[SHAMT_W-1:0]};

  alu_op_decode u_decode (
    .op  (win_op),
    .dec (win_dec)
  );

  assign accept         = (state == IDLE) && !rst && (bus.req0_valid || bus.req1_valid);
  assign bus.req0_ready = accept && !grant;
  assign bus.req1_ready = accept && grant;
  assign bus.rsp_valid  = (state == RESP);
  assign busy           = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      bus.rsp_id   <= 1'b0;
      bus.rsp_data <= '0;
      bus.rsp_err  <= 1'b0;
      op_count     <= '0;
      alu_in1      <= '0;
      alu_in2      <= '0;
      alu_sel      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= grant;
            bus.rsp_id <= grant;
            // Illegal ops skip the ALU so its inputs keep their last values.
            if (win_dec.legal) begin
              alu_in1 <= win_in1;
              alu_in2 <= win_dec.is_shift ? win_shamt : win_in2;
              alu_sel <= win_dec.sel;
              state   <= EXEC;
            end else begin
              bus.rsp_data <= '0;
              bus.rsp_err  <= 1'b1;
              state        <= RESP;
            end
          end
        end
        EXEC: begin
          bus.rsp_data <= alu_out;
          bus.rsp_err  <= 1'b0;
          state        <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            op_count <= op_count + 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational `alu` datapath between two requesters using round-robin arbitration.
- Each requester presents an opcode and two operands over a valid/ready handshake.
- The block decodes the opcode into the ALU's sel0..sel5 controls, drives the ALU from registered operands, captures the result and returns it with a requester ID over a valid/ready response channel.
- It sits between instruction-issue logic and the ALU.

Parameters:
- WIDTH, 32, operand and result width.
- SHAMT_W, 5, shift-amount bits kept from in2 on shift ops; equals log2(WIDTH).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  requester 0 op accepted this cycle.
- req0_op  in  4  requester 0 opcode.
- req0_in1  in  WIDTH  requester 0 operand 1.
- req0_in2  in  WIDTH  requester 0 operand 2.
- req1_valid, req1_ready, req1_op, req1_in1, req1_in2: same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_id  out  1  requester that issued the op.
- rsp_data  out  WIDTH  result.
- rsp_err  out  1  op was illegal.
- alu_in1  out  WIDTH  to ALU in1.
- alu_in2  out  WIDTH  to ALU in2.
- alu_sel  out  6  {sel5..sel0} to the ALU.
- alu_out  in  WIDTH  ALU result.
- busy  out  1  FSM not in IDLE.
- op_count  out  CNT_W  completed responses, wraps at 2^CNT_W.

Behaviour:
- Reset (synchronous, active-high) forces:
  - state to IDLE and last_grant to 1, so req0 wins first.
  - rsp_valid, rsp_err, rsp_id, rsp_data, op_count, alu_in1, alu_in2 and alu_sel to 0.
  - req*_ready to 0 during the reset cycle.
- Reset mid-operation discards the in-flight op; no response is produced.
- Opcode to {sel5..sel0} mapping:
  - 0 AND 000000
  - 1 OR 000001
  - 2 XOR 000010
  - 3 SLL 000110
  - 4 SRA 000100
  - 5 SRL 000101
  - 6 SNE 110001
  - 7 SLT 110010
  - 8 SGT 110011
  - 9 SLE 110100
  - 10 SGE 110110
  - 11 SUB 111000
  - 12 ADD 100000
  - 13-15 illegal.
- Shift ops (3, 4, 5): the captured in2 is zero-extended from its low SHAMT_W bits.
- FSM state IDLE:
  - Winner: if only one valid is high, that requester wins. If both are high, the requester not equal to last_grant wins.
  - req*_ready is combinational, high only for the winner, and only in IDLE.
  - On the handshake: capture op/in1/in2/id and set last_grant to the winner.
  - Legal op goes to EXEC. Illegal op goes to RESP with rsp_data=0 and rsp_err=1.
- FSM state EXEC (exactly 1 cycle):
  - alu_in1, alu_in2 and alu_sel are driven from the captured registers.
  - rsp_data is loaded from alu_out and rsp_err from 0; go to RESP.
  - alu_* outputs hold their last values in all other states.
- FSM state RESP:
  - rsp_valid=1; rsp_data, rsp_id and rsp_err are stable until the handshake.
  - On rsp_ready: increment op_count and go to IDLE.
  - No new op is accepted in RESP.
- Latency, accept to rsp_valid: legal op 2 cycles, illegal op 1 cycle.
- Minimum issue interval: 3 cycles legal, 2 cycles illegal.
- Backpressure: rsp_ready low holds RESP indefinitely; both requesters see ready=0.
- Requester valid dropping before ready is legal and never causes a grant.
- busy is high in EXEC and RESP.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - opcode localparams OP_AND..OP_ADD.
  - the 6-bit SEL_* constants.
  - FSM state encodings IDLE/EXEC/RESP.
- Sub-module alu_op_decode: combinational op to {sel, legal, is_shift}, reusable by the issue logic.

Test Plan:
- Reset, then req0 ADD with in1=5, in2=7 and rsp_ready=1 → alu_sel=100000 in EXEC; rsp_valid 2 cycles after accept with rsp_data=12, rsp_id=0, rsp_err=0; op_count=1.
- Both valid every cycle, req0 AND and req1 OR, rsp_ready=1 → grants alternate 0,1,0,1; rsp_id alternates 0,1,0,1.
- req1 SLL with in1=1, in2=32'hFFFF_FFE3 → alu_in2=3 and alu_sel=000110; rsp_data=8.
- req0 op=14 → rsp_valid 1 cycle after accept with rsp_err=1 and rsp_data=0; alu_sel unchanged.
- rsp_ready held low 5 cycles with req1_valid high → req1_ready stays 0; rsp fields are stable; req1 is accepted the cycle after the IDLE return.
- rst asserted in EXEC → next cycle IDLE, rsp_valid=0, op_count=0; no response is ever produced for the discarded op.
